pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the MIPS five-stage datapath, replacing the per-stage hand-written registers (F/D, D/E, E/M, M/W). It carries an opaque control/data payload together with a valid bit, instruction address, branch-delay flag and exception code. It supports hold (stall), bubble insertion and exception flush with a defined priority. It merges this stage's locally detected exception with the one arriving from upstream, and keeps saturating stall and bubble counters for performance checks.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/sat_counter.sv | 37 +++
 rtl/pipe_stage_reg.sv | 125 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS pipeline: exception-code width, ExcCode values, reset PC.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int EXC_W = 5;

  // MIPS Cause.ExcCode values used by the datapath; zero doubles as "no exception".
  localparam logic [EXC_W-1:0] EXC_NONE    = 5'd0;
  localparam logic [EXC_W-1:0] EXC_INT     = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL    = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES    = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYSCALL = 5'd8;
  localparam logic [EXC_W-1:0] EXC_RI      = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV      = 5'd12;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Latency: count reflects an increment one edge after inc is sampled.
// Backpressure: none; increments past all-ones are dropped (no wrap).
//   clk   : clock
//   RESET : synchronous active-high clear
//   inc   : add one this edge
//   count : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (F/D, D/E, E/M, M/W) with hold, bubble and flush control.
// Latency: 1 cycle, all outputs registered; no combinational input-to-output path.
// Backpressure: STALL holds contents; priority RESET > FLUSH > STALL > BUBBLE > load.
//   in_*  / out_*        : valid bit, opaque payload, instruction address, branch-delay flag, exception code
//   local_exc            : exception found by the driving stage, merged behind any upstream one
//   flush_pc             : address captured when the stage is flushed
//   stall_cnt/bubble_cnt : saturating performance counters, cleared only by RESET
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = 128,
  parameter int          EXC_W    = pipe_pkg::EXC_W,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] PC_RESET = pipe_pkg::PC_RESET
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              STALL,
  input  logic              BUBBLE,
  input  logic              FLUSH,
  input  logic [31:0]       flush_pc,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  input  logic              in_bd,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic [EXC_W-1:0]  local_exc,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic              out_bd,
  output logic [EXC_W-1:0]  out_exc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [31:0]       pc_q,    pc_d;
  logic              bd_q,    bd_d;
  logic [EXC_W-1:0]  exc_q,   exc_d;
  logic [EXC_W-1:0]  merged_exc;
  logic              stall_inc;
  logic              bubble_inc;

  // Oldest exception wins: an upstream code beats the one found here; empty slots carry none.
  always_comb begin
    merged_exc = '0;
    if (in_valid) begin
      merged_exc = (in_exc != '0) ? in_exc : local_exc;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    if (FLUSH) begin
      valid_d = 1'b0;
      data_d  = '0;
      pc_d    = flush_pc;
      bd_d    = 1'b0;
      exc_d   = '0;
    end else if (STALL) begin
      // hold everything
    end else if (BUBBLE) begin
      // PC/BD of the stalled instruction ride along so EPC and Cause.BD stay
      // correct if an interrupt is taken on the bubble.
      valid_d = 1'b0;
      data_d  = '0;
      pc_d    = in_pc;
      bd_d    = in_bd;
      exc_d   = '0;
    end else begin
      valid_d = in_valid;
      data_d  = in_data;
      pc_d    = in_pc;
      bd_d    = in_bd;
      exc_d   = merged_exc;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= PC_RESET;
      bd_q    <= 1'b0;
      exc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
      exc_q   <= exc_d;
    end
  end

  // Count only the action that actually wins the priority decode.
  assign stall_inc  = STALL && !FLUSH;
  assign bubble_inc = BUBBLE && !STALL && !FLUSH;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .RESET (RESET),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .RESET (RESET),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_pc    = pc_q;
  assign out_bd    = bd_q;
  assign out_exc   = exc_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         RESET, STALL, BUBBLE, FLUSH;
  logic [31:0]  flush_pc;
  logic         in_valid;
  logic [127:0] in_data;
  logic [31:0]  in_pc;
  logic         in_bd;
  logic [4:0]   in_exc, local_exc;

  logic         out_valid, s_out_valid;
  logic [127:0] out_data, s_out_data;
  logic [31:0]  out_pc, s_out_pc;
  logic         out_bd, s_out_bd;
  logic [4:0]   out_exc, s_out_exc;
  logic [15:0]  stall_cnt, bubble_cnt;
  logic [1:0]   s_stall_cnt, s_bubble_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .RESET(RESET), .STALL(STALL), .BUBBLE(BUBBLE), .FLUSH(FLUSH),
    .flush_pc(flush_pc), .in_valid(in_valid), .in_data(in_data), .in_pc(in_pc),
    .in_bd(in_bd), .in_exc(in_exc), .local_exc(local_exc),
    .out_valid(out_valid), .out_data(out_data), .out_pc(out_pc), .out_bd(out_bd),
    .out_exc(out_exc), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter copy driven with identical stimulus to exercise saturation.
  pipe_stage_reg #(.CNT_W(2)) dut_small (
    .clk(clk), .RESET(RESET), .STALL(STALL), .BUBBLE(BUBBLE), .FLUSH(FLUSH),
    .flush_pc(flush_pc), .in_valid(in_valid), .in_data(in_data), .in_pc(in_pc),
    .in_bd(in_bd), .in_exc(in_exc), .local_exc(local_exc),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_pc(s_out_pc), .out_bd(s_out_bd),
    .out_exc(s_out_exc), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  typedef struct {
    logic         valid;
    logic [127:0] data;
    logic [31:0]  pc;
    logic         bd;
    logic [4:0]   exc;
    int           scnt;
    int           bcnt;
  } exp_t;

  exp_t sb[$];
  exp_t m;        // reference architectural state
  exp_t e;        // monitor's popped entry
  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v >= maxv) ? maxv : v;
  endfunction

  // Drive one cycle of inputs, advance the reference model by the spec rules,
  // and queue the state expected after the coming rising edge.
  task automatic drive(input logic rst, input logic fl, input logic st, input logic bu,
                       input logic iv, input logic [127:0] d, input logic [31:0] pc,
                       input logic bd, input logic [4:0] ie, input logic [4:0] le,
                       input logic [31:0] fpc);
    @(negedge clk);
    RESET = rst; FLUSH = fl; STALL = st; BUBBLE = bu; in_valid = iv; in_data = d;
    in_pc = pc; in_bd = bd; in_exc = ie; local_exc = le; flush_pc = fpc;
    if (rst) begin
      m.valid = 0; m.data = 0; m.pc = 32'h0000_3000; m.bd = 0; m.exc = 0;
      m.scnt = 0; m.bcnt = 0;
    end else if (fl) begin
      m.valid = 0; m.data = 0; m.pc = fpc; m.bd = 0; m.exc = 0;
    end else if (st) begin
      m.scnt = m.scnt + 1;
    end else if (bu) begin
      m.valid = 0; m.data = 0; m.exc = 0; m.pc = pc; m.bd = bd;
      m.bcnt = m.bcnt + 1;
    end else begin
      m.valid = iv; m.data = d; m.pc = pc; m.bd = bd;
      if (!iv)          m.exc = 0;
      else if (ie != 0) m.exc = ie;
      else              m.exc = le;
    end
    sb.push_back(m);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: the register presents new state every cycle; compare just after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("out_valid", 128'(out_valid), 128'(e.valid));
      check("out_data",  out_data, e.data);
      check("out_pc",    128'(out_pc), 128'(e.pc));
      check("out_bd",    128'(out_bd), 128'(e.bd));
      check("out_exc",   128'(out_exc), 128'(e.exc));
      check("stall_cnt", 128'(stall_cnt), 128'(sat(e.scnt, 65535)));
      check("bubble_cnt", 128'(bubble_cnt), 128'(sat(e.bcnt, 65535)));
      check("small_out_pc", 128'(s_out_pc), 128'(e.pc));
      check("small_stall_cnt", 128'(s_stall_cnt), 128'(sat(e.scnt, 3)));
      check("small_bubble_cnt", 128'(s_bubble_cnt), 128'(sat(e.bcnt, 3)));
    end
  end

  initial begin
    RESET = 1; STALL = 0; BUBBLE = 0; FLUSH = 0; flush_pc = 0; in_valid = 0;
    in_data = 0; in_pc = 0; in_bd = 0; in_exc = 0; local_exc = 0;
    m = '{valid: 0, data: 0, pc: 0, bd: 0, exc: 0, scnt: 0, bcnt: 0};

    // reset with random inputs
    drive(1, $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), 1,
          rnd128(), $urandom, 1, 5'd12, 5'd8, $urandom);
    // exception merge: local only, then upstream wins
    drive(0, 0, 0, 0, 1, 128'h1, 32'h3004, 0, 5'd0, 5'd12, 0);
    drive(0, 0, 0, 0, 1, 128'h2, 32'h3008, 0, 5'd4, 5'd12, 0);
    drive(0, 0, 0, 0, 0, 128'h3, 32'h300c, 0, 5'd4, 5'd12, 0);
    // load A5 then stall 3 cycles with changing inputs, then release
    drive(0, 0, 0, 0, 1, 128'hA5, 32'h300c, 0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 3; i++)
      drive(0, 0, 1, 0, 1, rnd128(), $urandom, 1, 5'd10, 5'd5, $urandom);
    drive(0, 0, 0, 0, 1, 128'h5A, 32'h3010, 0, 5'd0, 5'd0, 0);
    // bubble, then stall+bubble
    drive(0, 0, 0, 1, 1, rnd128(), 32'h3010, 1, 5'd8, 5'd4, 0);
    drive(0, 0, 1, 1, 1, rnd128(), 32'h3014, 0, 5'd0, 5'd0, 0);
    // flush+stall
    drive(0, 1, 1, 0, 1, rnd128(), 32'h3018, 1, 5'd4, 5'd4, 32'h4180);
    // long stall saturates the 2-bit copy, then reset mid-stall
    for (int i = 0; i < 5; i++)
      drive(0, 0, 1, 0, 1, rnd128(), $urandom, 0, 5'd0, 5'd0, 0);
    drive(1, 0, 1, 0, 1, rnd128(), $urandom, 1, 5'd4, 5'd4, $urandom);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0,99) == 0, $urandom_range(0,19) == 0,
            $urandom_range(0,3) == 0, $urandom_range(0,4) == 0,
            $urandom_range(0,1) == 1, rnd128(), $urandom, $urandom_range(0,1) == 1,
            ($urandom_range(0,2) == 0) ? 5'($urandom_range(1,13)) : 5'd0,
            ($urandom_range(0,2) == 0) ? 5'($urandom_range(1,13)) : 5'd0, $urandom);
    end

    // let the monitor drain, bounded
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
